// File: rtl/int_ctrl_pkg.sv
// Shared state encoding, default sizing and the priority helper
// used by the interrupt controller.
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam int DEFAULT_NUM_IRQ = 8;
  localparam int DEFAULT_ID_W    = 3;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int unsigned lowest_set(input logic [31:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: two-flop synchronizer followed by a rising-edge
// detector, so a level-high input yields a single one-cycle event.
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic edge_o
);

  logic sync1_reg;
  logic sync2_reg;
  logic sync2_d_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      sync2_d_reg <= 1'b0;
    end else begin
      sync1_reg   <= irq;
      sync2_reg   <= sync1_reg;
      sync2_d_reg <= sync2_reg;
    end
  end

  assign edge_o = sync2_reg & ~sync2_d_reg;

endmodule

// File: rtl/int_controller.sv
// Interrupt controller: latches edge events as pending, masks, picks the
// lowest-index source and runs the INT / INT_ACK / eoi handshake.
module int_controller
  import int_ctrl_pkg::*;
#(
  parameter int NUM_IRQ = DEFAULT_NUM_IRQ,
  parameter int ID_W    = DEFAULT_ID_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic [NUM_IRQ-1:0] mask_o,
  output logic [NUM_IRQ-1:0] pending_o,
  output logic               INT,
  input  logic               INT_ACK,
  output logic [ID_W-1:0]    irq_id_o,
  input  logic               eoi
);

  logic [NUM_IRQ-1:0] edge_vec;
  logic [NUM_IRQ-1:0] pending_reg, pending_next;
  logic [NUM_IRQ-1:0] mask_reg;
  logic [NUM_IRQ-1:0] clr_vec;
  logic [NUM_IRQ-1:0] active;
  logic [31:0]        active_ext;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    id_reg, id_next;
  logic               int_reg, int_next;
  state_t             state_reg, state_next;

  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
    irq_sync_edge u_sync (
      .clk    (clk),
      .reset  (reset),
      .irq    (irq_i[gi]),
      .edge_o (edge_vec[gi])
    );
  end

  assign active     = pending_reg & mask_reg;
  assign active_ext = 32'(active);
  assign winner     = ID_W'(lowest_set(active_ext));

  // A new event on the acknowledged source outranks its clear.
  assign pending_next = (pending_reg & ~clr_vec) | edge_vec;

  always_comb begin
    state_next = state_reg;
    int_next   = int_reg;
    id_next    = id_reg;
    clr_vec    = '0;
    unique case (state_reg)
      IDLE: begin
        if (|active) begin
          state_next = REQ;
          int_next   = 1'b1;
          id_next    = winner;
        end
      end
      REQ: begin
        if (INT_ACK) begin
          state_next = SERVICE;
          int_next   = 1'b0;
          clr_vec    = NUM_IRQ'(1) << id_reg;
        end
      end
      SERVICE: begin
        if (eoi) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        int_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      int_reg     <= 1'b0;
      id_reg      <= '0;
      pending_reg <= '0;
      mask_reg    <= '1;
    end else begin
      state_reg   <= state_next;
      int_reg     <= int_next;
      id_reg      <= id_next;
      pending_reg <= pending_next;
      if (mask_we) mask_reg <= mask_wdata;
    end
  end

  assign INT       = int_reg;
  assign irq_id_o  = id_reg;
  assign pending_o = pending_reg;
  assign mask_o    = mask_reg;

endmodule
